// File: rtl/piso_pkg.sv
// Shared types and default constants for the parallel-in serial-out transmitter
// and its bit-period tick generator.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF   = 4;
    localparam int DIV_MAX_SIM = 3;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable tick generator: counts 0..DIV_MAX while enabled and strobes
// tick on the terminal count. Shared by the transmit and receive sides.
module tick_gen #(
    parameter int DIV_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(DIV_MAX);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TC);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TC) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a word via valid/ready and shifts
// it out MSB-first, one bit per DIV_MAX+1 clk cycles, with frame/tick/done flags.
module piso_tx
    import piso_pkg::*;
#(
    parameter int   WIDTH    = WIDTH_DEF,
    parameter int   DIV_MAX  = 33554431,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    output logic             sout,
    output logic             frame,
    output logic             bit_tick,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bcnt;

    // Divider is held clear throughout IDLE, so every frame starts at count 0.
    tick_gen #(
        .DIV_MAX(DIV_MAX)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (state == SHIFT),
        .clr (state == IDLE),
        .tick(bit_tick)
    );

    // Status outputs decode straight from registers, so they carry no glitches
    // and no added latency.
    assign ld_ready = (state == IDLE);
    assign frame    = (state == SHIFT);
    assign sout     = (state == SHIFT) ? shreg[WIDTH-1] : IDLE_LVL;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            bcnt  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        shreg <= ld_data;
                        bcnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        if (bcnt == LAST_BIT) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            bcnt  <= bcnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
